instr_reg_scheduler: RTL and testbench
======================================

Name: instr_reg_scheduler

Overview:
Controller and arbiter that shares one instr_register instance between two instruction requesters.
- Arbitrates round-robin between the requesters.
- Drives load_en, write_pointer, opcode and operands into the register.
- Reads the stored word back through read_pointer and returns the computed result to the winning requester.
- Sits directly above instr_register in the lab_dut hierarchy and is the only block that drives its inputs.

Parameters:
DEPTH, 32, number of instruction slots in instr_register; write_pointer wraps modulo DEPTH
PTR_W, $clog2(DEPTH) = 5, width of slot pointers (matches address_t)

Ports:
clk  input  1  system clock, all state updates on posedge
reset  input  1  synchronous, active-high reset
req0_valid  input  1  requester 0 has an instruction
req0_ready  output  1  requester 0 instruction accepted this cycle
req0_opcode  input  opcode_t  requester 0 operation
req0_operand_a  input  operand_t  requester 0 operand A
req0_operand_b  input  operand_t  requester 0 operand B
req1_valid / req1_ready / req1_opcode / req1_operand_a / req1_operand_b  same as requester 0
rsp_valid  output  1  response available
rsp_ready  input  1  response consumer accepts
rsp_id  output  1  requester that owns the response (0/1)
rsp_slot  output  PTR_W  slot the instruction was written to
rsp_result  output  result_t  result field read back from instruction_word
load_en  output  1  to instr_register
opcode  output  opcode_t  to instr_register
operand_a  output  operand_t  to instr_register
operand_b  output  operand_t  to instr_register
write_pointer  output  address_t  to instr_register
read_pointer  output  address_t  to instr_register
instruction_word  input  instruction_t  from instr_register
wr_count  output  PTR_W+1  instructions written since reset, saturating at DEPTH

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high. At integration, instr_register reset_n is driven by ~reset.
- Reset values: all outputs 0; opcode = ZERO; FSM in IDLE; round-robin priority favours req0; internal write pointer wp = 0.
- FSM states: IDLE, LOAD, READ, RESP.
- IDLE:
  - If any reqN_valid, grant one requester: round-robin, with priority to the requester not granted last.
  - reqN_ready is asserted combinationally for the winner only; at most one ready per cycle.
  - Capture opcode and operands into output registers; go to LOAD.
  - readys are 0 in every other state.
- LOAD: load_en = 1 for exactly one cycle; write_pointer = wp. Go to READ.
- READ:
  - read_pointer = wp.
  - Register rsp_result <= instruction_word.result, rsp_slot <= wp and rsp_id <= winner.
  - wp <= (wp+1) mod DEPTH; wr_count increments, saturating at DEPTH. Go to RESP.
- RESP:
  - rsp_valid = 1.
  - rsp_id, rsp_slot and rsp_result stay stable until rsp_ready is sampled high; then rsp_valid = 0 next cycle and go to IDLE.
- Latency: accept at cycle T, load_en at T+1, capture at T+2, rsp_valid at T+3 at the earliest. Throughput is at most one instruction per 4 cycles.
- Output hold: outside LOAD, load_en = 0, and opcode, operands and write_pointer hold their last values. read_pointer holds its last value outside READ.
- Wrap-around: after slot DEPTH-1 the next write goes to slot 0 and overwrites the old contents; no full condition, no stall.
- Simultaneous valids: both requesters are served alternately. A requester's valid may drop while it is not granted; no state is kept for it.
- Backpressure: while rsp_ready = 0 in RESP, no new request is accepted.
- Reset mid-operation: return to IDLE next cycle, discard the in-flight instruction, rsp_valid = 0, wp = 0, wr_count = 0. instr_register contents are cleared by its own reset_n.
- Arithmetic: the scheduler performs none; rsp_result is exactly the stored result field, width result_t.

Decomposition:
- instr_register_pkg adds:
  - sched_state_t enum {IDLE, LOAD, READ, RESP}
  - req_t struct {opcode_t opc; operand_t op_a; operand_t op_b}
  - constant NUM_REQ = 2
- One sub-module: rr_arbiter2. Inputs: valid[1:0] and last_grant. Outputs: one-hot grant. Purely combinational; the last_grant register lives in the scheduler.

Test Plan:
- Single request: req0 ADD a=5 b=3 -> req0_ready at T, load_en high only at T+1 with write_pointer 0, rsp_valid at T+3 with rsp_id 0, rsp_slot 0, rsp_result 8.
- Simultaneous: req0 MULT 4*6 and req1 SUB 10-7 both valid -> req0 served first (slot 0, result 24), then req1 (slot 1, result 3); req1_ready never coincides with req0_ready.
- Divide by zero: req1 DIV a=9 b=0 -> rsp_result 0, rsp_id 1.
- Wrap-around: 33 sequential PASSA requests with a = index -> slots 0..31 then 0; 33rd rsp_slot 0, rsp_result 32; wr_count saturates at 32.
- Backpressure: rsp_ready held 0 for 5 cycles with req1_valid high -> rsp fields stable, rsp_valid held, req1_ready stays 0 until one cycle after rsp_ready goes high.
- Reset mid-LOAD: assert reset during LOAD -> next cycle all outputs 0 and FSM IDLE; next request written to slot 0 with wr_count 1.

Source files
------------

// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and the scheduler that fronts it.
package instr_register_pkg;

  typedef enum logic [3:0] {
    ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD
  } opcode_t;

  typedef logic signed [31:0] operand_t;
  typedef logic signed [63:0] result_t;
  typedef logic [4:0]         address_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
    result_t  result;
  } instruction_t;

  typedef enum logic [1:0] {IDLE, LOAD, READ, RESP} sched_state_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } req_t;

  localparam int NUM_REQ    = 2;
  localparam int SLOT_DEPTH = 32;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: on contention the requester not granted last wins.
module rr_arbiter2
  import instr_register_pkg::*;
(
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic               last_grant_i,
  output logic [NUM_REQ-1:0] grant_o
);

  // last_grant_i = 1 means requester 1 was served last, so requester 0 has priority.
  assign grant_o[0] = valid_i[0] & (~valid_i[1] |  last_grant_i);
  assign grant_o[1] = valid_i[1] & (~valid_i[0] | ~last_grant_i);

endmodule

// File: rtl/instr_reg_scheduler.sv
// Arbitrates two requesters onto one instr_register: load a slot, read it back,
// and hand the stored result to the winner.
module instr_reg_scheduler
  import instr_register_pkg::*;
#(
  parameter int DEPTH = SLOT_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  opcode_t            req0_opcode,
  input  operand_t           req0_operand_a,
  input  operand_t           req0_operand_b,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  opcode_t            req1_opcode,
  input  operand_t           req1_operand_a,
  input  operand_t           req1_operand_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [PTR_W-1:0]   rsp_slot,
  output result_t            rsp_result,
  output logic               load_en,
  output opcode_t            opcode,
  output operand_t           operand_a,
  output operand_t           operand_b,
  output address_t           write_pointer,
  output address_t           read_pointer,
  input  instruction_t       instruction_word,
  output logic [PTR_W:0]     wr_count
);

  sched_state_t        state_q;
  logic                last_grant_q;
  logic [PTR_W-1:0]    wp_q, wp_d;
  logic [PTR_W:0]      wr_count_q, wr_count_d;
  logic                load_en_q, rsp_valid_q, rsp_id_q;
  logic [PTR_W-1:0]    rsp_slot_q;
  result_t             rsp_result_q;
  opcode_t             opcode_q;
  operand_t            operand_a_q, operand_b_q;
  address_t            write_pointer_q, read_pointer_q;

  logic [NUM_REQ-1:0]  req_valid, grant;
  req_t                req_sel;
  logic                unused_iw;

  assign req_valid = {req1_valid, req0_valid};

  rr_arbiter2 u_arb (
    .valid_i      (req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  always_comb begin
    req_sel = '{opc: req0_opcode, op_a: req0_operand_a, op_b: req0_operand_b};
    if (grant[1]) begin
      req_sel = '{opc: req1_opcode, op_a: req1_operand_a, op_b: req1_operand_b};
    end
  end

  // Slot pointer wraps silently; older contents are simply overwritten.
  assign wp_d       = (wp_q == PTR_W'(DEPTH - 1)) ? '0 : wp_q + PTR_W'(1);
  assign wr_count_d = (wr_count_q == (PTR_W+1)'(DEPTH)) ? wr_count_q
                                                         : wr_count_q + (PTR_W+1)'(1);

  assign req0_ready = (state_q == IDLE) && grant[0];
  assign req1_ready = (state_q == IDLE) && grant[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      last_grant_q    <= 1'b1;
      wp_q            <= '0;
      wr_count_q      <= '0;
      load_en_q       <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_id_q        <= 1'b0;
      rsp_slot_q      <= '0;
      rsp_result_q    <= '0;
      opcode_q        <= ZERO;
      operand_a_q     <= '0;
      operand_b_q     <= '0;
      write_pointer_q <= '0;
      read_pointer_q  <= '0;
    end else begin
      load_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|grant) begin
            opcode_q        <= req_sel.opc;
            operand_a_q     <= req_sel.op_a;
            operand_b_q     <= req_sel.op_b;
            write_pointer_q <= address_t'(wp_q);
            last_grant_q    <= grant[1];
            load_en_q       <= 1'b1;
            state_q         <= LOAD;
          end
        end
        // Register writes at the end of LOAD; point the read port at it for READ.
        LOAD: begin
          read_pointer_q <= address_t'(wp_q);
          state_q        <= READ;
        end
        READ: begin
          rsp_result_q <= instruction_word.result;
          rsp_slot_q   <= wp_q;
          rsp_id_q     <= last_grant_q;
          rsp_valid_q  <= 1'b1;
          wp_q         <= wp_d;
          wr_count_q   <= wr_count_d;
          state_q      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid     = rsp_valid_q;
  assign rsp_id        = rsp_id_q;
  assign rsp_slot      = rsp_slot_q;
  assign rsp_result    = rsp_result_q;
  assign load_en       = load_en_q;
  assign opcode        = opcode_q;
  assign operand_a     = operand_a_q;
  assign operand_b     = operand_b_q;
  assign write_pointer = write_pointer_q;
  assign read_pointer  = read_pointer_q;
  assign wr_count      = wr_count_q;

  // Only the result field is consumed from the stored word.
  assign unused_iw = ^{instruction_word.opc, instruction_word.op_a, instruction_word.op_b};

endmodule

// File: tb/tb_instr_reg_scheduler.sv
// Directed bench for instr_reg_scheduler with a behavioural instr_register and a response scoreboard.
module tb_instr_reg_scheduler;
  import instr_register_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  opcode_t      req0_opcode = ZERO, req1_opcode = ZERO;
  operand_t     req0_operand_a = '0, req0_operand_b = '0;
  operand_t     req1_operand_a = '0, req1_operand_b = '0;
  logic         rsp_valid, rsp_id;
  logic         rsp_ready = 1'b1;
  logic [4:0]   rsp_slot;
  result_t      rsp_result;
  logic         load_en;
  opcode_t      opcode;
  operand_t     operand_a, operand_b;
  address_t     write_pointer, read_pointer;
  instruction_t instruction_word;
  logic [5:0]   wr_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic     id;
    address_t slot;
    result_t  res;
  } exp_t;
  exp_t sb[$];

  instr_reg_scheduler dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_operand_a(req0_operand_a), .req0_operand_b(req0_operand_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_operand_a(req1_operand_a), .req1_operand_b(req1_operand_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_slot(rsp_slot), .rsp_result(rsp_result),
    .load_en(load_en), .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
    .write_pointer(write_pointer), .read_pointer(read_pointer),
    .instruction_word(instruction_word), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  function automatic result_t calc(opcode_t o, operand_t a, operand_t b);
    case (o)
      PASSA:   calc = result_t'(a);
      PASSB:   calc = result_t'(b);
      ADD:     calc = result_t'(a) + result_t'(b);
      SUB:     calc = result_t'(a) - result_t'(b);
      MULT:    calc = result_t'(a) * result_t'(b);
      DIV:     calc = (b == 0) ? '0 : result_t'(a) / result_t'(b);
      MOD:     calc = (b == 0) ? '0 : result_t'(a) % result_t'(b);
      default: calc = '0;
    endcase
  endfunction

  instruction_t mem [32];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (load_en) begin
      mem[write_pointer] <= '{opc: opcode, op_a: operand_a, op_b: operand_b,
                              result: calc(opcode, operand_a, operand_b)};
    end
  end
  assign instruction_word = mem[read_pointer];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic compare_pop();
    exp_t e;
    check("sb_has_entry", 64'(sb.size() > 0), 64'(1));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("rsp_id", 64'(rsp_id), 64'(e.id));
      check("rsp_slot", 64'(rsp_slot), 64'(e.slot));
      check("rsp_result", 64'(rsp_result), 64'(e.res));
    end
  endtask

  // Runs until every expected response has been seen; drops valids once accepted.
  task automatic drain(input int budget);
    int  n;
    logic a0, a1;
    n = 0;
    while (sb.size() > 0 && n < budget) begin
      @(negedge clk);
      a0 = req0_ready;
      a1 = req1_ready;
      if (a0 | a1) check("ready_exclusive", 64'(a0 & a1), 64'(0));
      if (rsp_valid && rsp_ready) compare_pop();
      step();
      if (a0) req0_valid = 1'b0;
      if (a1) req1_valid = 1'b0;
      n++;
    end
    check("drain_empty", 64'(sb.size()), 64'(0));
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
    check({pfx, "_load_en"}, 64'(load_en), 64'(0));
    check({pfx, "_opcode"}, 64'(opcode), 64'(ZERO));
    check({pfx, "_operand_a"}, 64'(operand_a), 64'(0));
    check({pfx, "_operand_b"}, 64'(operand_b), 64'(0));
    check({pfx, "_write_pointer"}, 64'(write_pointer), 64'(0));
    check({pfx, "_read_pointer"}, 64'(read_pointer), 64'(0));
    check({pfx, "_rsp_id"}, 64'(rsp_id), 64'(0));
    check({pfx, "_rsp_slot"}, 64'(rsp_slot), 64'(0));
    check({pfx, "_rsp_result"}, 64'(rsp_result), 64'(0));
    check({pfx, "_wr_count"}, 64'(wr_count), 64'(0));
    check({pfx, "_readys"}, 64'({req1_ready, req0_ready}), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int   got;
    exp_t e;

    // Reset state
    do_reset();
    @(negedge clk);
    check_zero("reset");

    // Single request with cycle-exact timing
    step();
    req0_opcode = ADD; req0_operand_a = 5; req0_operand_b = 3; req0_valid = 1'b1;
    sb.push_back('{1'b0, 5'd0, 64'sd8});
    @(negedge clk);
    check("single_ready0_T", 64'(req0_ready), 64'(1));
    check("single_ready1_T", 64'(req1_ready), 64'(0));
    check("single_load_en_T", 64'(load_en), 64'(0));
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    check("single_load_en_T1", 64'(load_en), 64'(1));
    check("single_wp_T1", 64'(write_pointer), 64'(0));
    check("single_opcode_T1", 64'(opcode), 64'(ADD));
    check("single_op_a_T1", 64'(operand_a), 64'(5));
    check("single_op_b_T1", 64'(operand_b), 64'(3));
    check("single_ready0_T1", 64'(req0_ready), 64'(0));
    step();
    @(negedge clk);
    check("single_load_en_T2", 64'(load_en), 64'(0));
    check("single_rp_T2", 64'(read_pointer), 64'(0));
    check("single_rsp_valid_T2", 64'(rsp_valid), 64'(0));
    step();
    @(negedge clk);
    check("single_rsp_valid_T3", 64'(rsp_valid), 64'(1));
    compare_pop();
    step();
    @(negedge clk);
    check("single_rsp_valid_T4", 64'(rsp_valid), 64'(0));
    check("single_wr_count", 64'(wr_count), 64'(1));

    // Simultaneous requests from a fresh reset: req0 first
    do_reset();
    req0_opcode = MULT; req0_operand_a = 4;  req0_operand_b = 6;
    req1_opcode = SUB;  req1_operand_a = 10; req1_operand_b = 7;
    req0_valid = 1'b1; req1_valid = 1'b1;
    sb.push_back('{1'b0, 5'd0, 64'sd24});
    sb.push_back('{1'b1, 5'd1, 64'sd3});
    drain(40);

    // Divide by zero from requester 1
    step();
    req1_opcode = DIV; req1_operand_a = 9; req1_operand_b = 0; req1_valid = 1'b1;
    sb.push_back('{1'b1, 5'd2, 64'sd0});
    drain(20);

    // Backpressure with requester 1 waiting
    step();
    rsp_ready = 1'b0;
    req0_opcode = ADD; req0_operand_a = 100; req0_operand_b = -1; req0_valid = 1'b1;
    sb.push_back('{1'b0, 5'd3, 64'sd99});
    got = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      @(negedge clk);
      if (req0_ready) got = 1;
      else step();
    end
    check("bp_grant", 64'(got), 64'(1));
    step();
    req0_valid = 1'b0;
    req1_opcode = SUB; req1_operand_a = 7; req1_operand_b = 2; req1_valid = 1'b1;
    sb.push_back('{1'b1, 5'd4, 64'sd5});
    got = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      @(negedge clk);
      if (rsp_valid) got = 1;
    end
    check("bp_rsp_seen", 64'(got), 64'(1));
    e = sb[0];
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        step();
        @(negedge clk);
      end
      check("bp_rsp_valid_hold", 64'(rsp_valid), 64'(1));
      check("bp_rsp_id_hold", 64'(rsp_id), 64'(e.id));
      check("bp_rsp_slot_hold", 64'(rsp_slot), 64'(e.slot));
      check("bp_rsp_result_hold", 64'(rsp_result), 64'(e.res));
      check("bp_ready1_blocked", 64'(req1_ready), 64'(0));
    end
    step();
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_rsp_valid_release", 64'(rsp_valid), 64'(1));
    check("bp_ready1_release", 64'(req1_ready), 64'(0));
    compare_pop();
    step();
    @(negedge clk);
    check("bp_rsp_valid_after", 64'(rsp_valid), 64'(0));
    check("bp_ready1_after", 64'(req1_ready), 64'(1));
    step();
    req1_valid = 1'b0;
    drain(20);
    check("bp_wr_count", 64'(wr_count), 64'(5));

    // Reset while in LOAD
    step();
    req0_opcode = PASSB; req0_operand_a = 0; req0_operand_b = 55; req0_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      @(negedge clk);
      if (req0_ready) got = 1;
      else step();
    end
    check("rml_grant", 64'(got), 64'(1));
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    check("rml_load_en", 64'(load_en), 64'(1));
    check("rml_wp", 64'(write_pointer), 64'(5));
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    check_zero("rml");
    step();
    req1_opcode = PASSA; req1_operand_a = 77; req1_operand_b = 0; req1_valid = 1'b1;
    sb.push_back('{1'b1, 5'd0, 64'sd77});
    drain(20);
    check("rml_wr_count", 64'(wr_count), 64'(1));

    // Wrap-around and wr_count saturation
    do_reset();
    for (int i = 0; i < 33; i++) begin
      step();
      req0_opcode = PASSA; req0_operand_a = i; req0_operand_b = 0; req0_valid = 1'b1;
      sb.push_back('{1'b0, address_t'(i % 32), result_t'(i)});
      drain(20);
      check("wrap_wr_count", 64'(wr_count), 64'((i < 32) ? i + 1 : 32));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
